// File: rtl/pc_sequencer.sv
// Fetch/execute/interrupt sequencer for the RAT MCU program counter, with a return-address stack.
// Define PC_SEQ_INTR_LATCH_EN to latch INTR pulses until the sequencer can take them.
module pc_sequencer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 10
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] PC_COUNT,
    input  logic [2:0]    OP_CLASS,
    input  logic [1:0]    COND,
    input  logic          C_FLAG,
    input  logic          Z_FLAG,
    input  logic          INTR,
    output logic          PC_LD,
    output logic          PC_INC,
    output logic [1:0]    PC_MUX_SEL,
    output logic [AW-1:0] STACK_DOUT,
    output logic          INT_EN,
    output logic          STACK_EMPTY,
    output logic          STACK_FULL,
    output logic          STACK_ERR,
    output logic [1:0]    STATE
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam logic [PW-1:0] FullCnt = PW'(DEPTH);

    localparam logic [2:0] OpOther  = 3'd0;
    localparam logic [2:0] OpJmp    = 3'd1;
    localparam logic [2:0] OpBranch = 3'd2;
    localparam logic [2:0] OpCall   = 3'd3;
    localparam logic [2:0] OpRet    = 3'd4;
    localparam logic [2:0] OpRetie  = 3'd5;
    localparam logic [2:0] OpRetid  = 3'd6;
    localparam logic [2:0] OpIntctl = 3'd7;

    localparam logic [1:0] SelImm = 2'd0;
    localparam logic [1:0] SelStk = 2'd1;
    localparam logic [1:0] SelVec = 2'd2;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StExec  = 2'd1,
        StIntr  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          int_en_q, int_en_d;
    logic [PW-1:0] ptr_q;
    logic          err_q;
    logic [AW-1:0] mem_q [DEPTH];

    logic          ld, inc;
    logic [1:0]    sel;
    logic          push, pop;
    logic [AW-1:0] push_val;
    logic          taken;
    logic          intr_req;
    logic          empty, full;
    logic [IW-1:0] top_idx;

`ifdef PC_SEQ_INTR_LATCH_EN
    logic pend_q;

    // Clear beats set so a pulse coinciding with the entry edge is consumed by it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q <= 1'b0;
        end else if (state_d == StIntr) begin
            pend_q <= 1'b0;
        end else if (INTR) begin
            pend_q <= 1'b1;
        end
    end

    assign intr_req = pend_q | INTR;
`else
    assign intr_req = INTR;
`endif

    assign empty   = (ptr_q == '0);
    assign full    = (ptr_q == FullCnt);
    assign top_idx = ptr_q[IW-1:0] - IW'(1);

    always_comb begin
        unique case (COND)
            2'd0: taken = ~C_FLAG;
            2'd1: taken = C_FLAG;
            2'd2: taken = Z_FLAG;
            2'd3: taken = ~Z_FLAG;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        int_en_d = int_en_q;
        ld       = 1'b0;
        inc      = 1'b0;
        sel      = SelImm;
        push     = 1'b0;
        pop      = 1'b0;
        push_val = PC_COUNT;
        unique case (state_q)
            StFetch: state_d = StExec;
            StExec: begin
                unique case (OP_CLASS)
                    OpOther: inc = 1'b1;
                    OpJmp:   ld  = 1'b1;
                    OpBranch: begin
                        ld  = taken;
                        inc = ~taken;
                    end
                    OpCall: begin
                        push     = 1'b1;
                        push_val = PC_COUNT + AW'(1);
                        ld       = 1'b1;
                    end
                    OpRet, OpRetie, OpRetid: begin
                        pop = 1'b1;
                        ld  = 1'b1;
                        sel = SelStk;
                        if (OP_CLASS == OpRetie) int_en_d = 1'b1;
                        if (OP_CLASS == OpRetid) int_en_d = 1'b0;
                    end
                    OpIntctl: begin
                        int_en_d = COND[0];
                        inc      = 1'b1;
                    end
                    default: inc = 1'b1;
                endcase
                // Decision uses the enable held before this edge, not int_en_d.
                state_d = (intr_req && int_en_q) ? StIntr : StFetch;
            end
            StIntr: begin
                push     = 1'b1;
                push_val = PC_COUNT;
                ld       = 1'b1;
                sel      = SelVec;
                int_en_d = 1'b0;
                state_d  = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StFetch;
            int_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            int_en_q <= int_en_d;
        end
    end

    // Overflowed pushes and underflowed pops leave the pointer alone but latch the error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else if (push) begin
            if (full) err_q <= 1'b1;
            else      ptr_q <= ptr_q + PW'(1);
        end else if (pop) begin
            if (empty) err_q <= 1'b1;
            else       ptr_q <= ptr_q - PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && push && !full) begin
            mem_q[ptr_q[IW-1:0]] <= push_val;
        end
    end

    assign PC_LD       = ld & ~RST;
    assign PC_INC      = inc & ~RST;
    assign PC_MUX_SEL  = RST ? SelImm : sel;
    assign STACK_DOUT  = empty ? '0 : mem_q[top_idx];
    assign INT_EN      = int_en_q;
    assign STACK_EMPTY = empty;
    assign STACK_FULL  = full;
    assign STACK_ERR   = err_q;
    assign STATE       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed instructions queue expected PC strobes,
// a negedge monitor pops and compares them; a small PC register closes the loop.
module tb_pc_sequencer;

    localparam logic [2:0] OpOther  = 3'd0;
    localparam logic [2:0] OpBranch = 3'd2;
    localparam logic [2:0] OpCall   = 3'd3;
    localparam logic [2:0] OpRet    = 3'd4;
    localparam logic [2:0] OpRetie  = 3'd5;
    localparam logic [2:0] OpIntctl = 3'd7;

    logic       CLK = 1'b0;
    logic       RST;
    logic [9:0] PC_COUNT;
    logic [2:0] OP_CLASS;
    logic [1:0] COND;
    logic       C_FLAG, Z_FLAG, INTR;
    logic       PC_LD, PC_INC;
    logic [1:0] PC_MUX_SEL;
    logic [9:0] STACK_DOUT;
    logic       INT_EN, STACK_EMPTY, STACK_FULL, STACK_ERR;
    logic [1:0] STATE;

    logic [9:0] pc;
    logic [9:0] imm;
    logic       pc_set;
    logic [9:0] pc_set_val;

    typedef struct {
        logic       ld;
        logic       inc;
        logic [1:0] sel;
        logic [9:0] dout;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pc_sequencer #(.DEPTH(8), .AW(10)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PC_COUNT    (PC_COUNT),
        .OP_CLASS    (OP_CLASS),
        .COND        (COND),
        .C_FLAG      (C_FLAG),
        .Z_FLAG      (Z_FLAG),
        .INTR        (INTR),
        .PC_LD       (PC_LD),
        .PC_INC      (PC_INC),
        .PC_MUX_SEL  (PC_MUX_SEL),
        .STACK_DOUT  (STACK_DOUT),
        .INT_EN      (INT_EN),
        .STACK_EMPTY (STACK_EMPTY),
        .STACK_FULL  (STACK_FULL),
        .STACK_ERR   (STACK_ERR),
        .STATE       (STATE)
    );

    always #5 CLK = ~CLK;

    assign PC_COUNT = pc;

    // Program counter and its mux, as they sit outside the sequencer.
    always @(posedge CLK) begin
        if (pc_set)      pc <= pc_set_val;
        else if (RST)    pc <= pc;
        else if (PC_LD)  pc <= (PC_MUX_SEL == 2'd0) ? imm :
                               (PC_MUX_SEL == 2'd1) ? STACK_DOUT : 10'h3FF;
        else if (PC_INC) pc <= pc + 10'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RST === 1'b0 && (PC_LD || PC_INC)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, PC_LD, PC_INC}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("pc_ld", PC_LD, e.ld);
                check("pc_inc", PC_INC, e.inc);
                check("mux_sel", PC_MUX_SEL, e.sel);
                if (e.sel == 2'd1) check("ret_stack_dout", STACK_DOUT, e.dout);
            end
        end
    end

    // Runs one instruction starting in FETCH; start < 0 keeps the current PC.
    task automatic instr(input logic [2:0] op, input logic [1:0] cond, input logic [9:0] im,
                         input int start, input logic e_ld, input logic e_inc,
                         input logic [1:0] e_sel, input logic [9:0] e_dout,
                         input logic take_intr, input logic [9:0] e_pc);
        exp_t e;
        OP_CLASS = op;
        COND     = cond;
        imm      = im;
        if (start >= 0) begin
            pc_set     = 1'b1;
            pc_set_val = start[9:0];
        end
        e = '{e_ld, e_inc, e_sel, e_dout};
        sb_q.push_back(e);
        if (take_intr) begin
            e = '{1'b1, 1'b0, 2'd2, 10'd0};
            sb_q.push_back(e);
        end
        @(posedge CLK); #1;
        pc_set = 1'b0;
        check("state_exec", STATE, 2'd1);
        @(posedge CLK); #1;
        if (take_intr) begin
            check("state_intr", STATE, 2'd2);
            @(posedge CLK); #1;
        end
        check("state_fetch", STATE, 2'd0);
        check("pc_after", pc, e_pc);
        check("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        RST = 1'b1; OP_CLASS = OpOther; COND = 2'd0; C_FLAG = 1'b0; Z_FLAG = 1'b0;
        INTR = 1'b0; imm = 10'd0; pc_set = 1'b1; pc_set_val = 10'd0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_state", STATE, 2'd0);
        check("rst_pc_ld", PC_LD, 1'b0);
        check("rst_pc_inc", PC_INC, 1'b0);
        check("rst_sel", PC_MUX_SEL, 2'd0);
        check("rst_empty", STACK_EMPTY, 1'b1);
        check("rst_full", STACK_FULL, 1'b0);
        check("rst_int_en", INT_EN, 1'b0);
        check("rst_err", STACK_ERR, 1'b0);
        RST = 1'b0; pc_set = 1'b0;

        // Sequential instructions
        instr(OpOther, 2'd0, 10'd0, 0, 1'b0, 1'b1, 2'd0, 10'd0, 1'b0, 10'd1);
        instr(OpOther, 2'd0, 10'd0, -1, 1'b0, 1'b1, 2'd0, 10'd0, 1'b0, 10'd2);
        instr(OpOther, 2'd0, 10'd0, -1, 1'b0, 1'b1, 2'd0, 10'd0, 1'b0, 10'd3);

        // CALL / RET
        instr(OpCall, 2'd0, 10'h020, 5, 1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 10'h020);
        check("call_top", STACK_DOUT, 10'h006);
        check("call_not_empty", STACK_EMPTY, 1'b0);
        instr(OpRet, 2'd0, 10'd0, -1, 1'b1, 1'b0, 2'd1, 10'h006, 1'b0, 10'h006);
        check("ret_empty", STACK_EMPTY, 1'b1);

        // Branches
        Z_FLAG = 1'b1;
        instr(OpBranch, 2'd2, 10'h0A0, 10'h030, 1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 10'h0A0);
        Z_FLAG = 1'b0;
        instr(OpBranch, 2'd2, 10'h0B0, 10'h040, 1'b0, 1'b1, 2'd0, 10'd0, 1'b0, 10'h041);
        instr(OpBranch, 2'd3, 10'h0C0, 10'h050, 1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 10'h0C0);
        C_FLAG = 1'b1;
        instr(OpBranch, 2'd1, 10'h0D0, 10'h060, 1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 10'h0D0);
        instr(OpBranch, 2'd0, 10'h0E0, 10'h070, 1'b0, 1'b1, 2'd0, 10'd0, 1'b0, 10'h071);
        C_FLAG = 1'b0;

        // Interrupts
        instr(OpIntctl, 2'd1, 10'd0, 10'h00F, 1'b0, 1'b1, 2'd0, 10'd0, 1'b0, 10'h010);
        check("sei_int_en", INT_EN, 1'b1);
        INTR = 1'b1;
        instr(OpOther, 2'd0, 10'd0, 10'h010, 1'b0, 1'b1, 2'd0, 10'd0, 1'b1, 10'h3FF);
        INTR = 1'b0;
        check("intr_int_en", INT_EN, 1'b0);
        check("intr_pushed", STACK_DOUT, 10'h011);
        instr(OpRetie, 2'd0, 10'd0, -1, 1'b1, 1'b0, 2'd1, 10'h011, 1'b0, 10'h011);
        check("retie_int_en", INT_EN, 1'b1);
        instr(OpIntctl, 2'd0, 10'd0, 10'h100, 1'b0, 1'b1, 2'd0, 10'd0, 1'b0, 10'h101);
        check("cli_int_en", INT_EN, 1'b0);
        INTR = 1'b1;
        instr(OpOther, 2'd0, 10'd0, -1, 1'b0, 1'b1, 2'd0, 10'd0, 1'b0, 10'h102);
        INTR = 1'b0;

        // Overflow then underflow
        for (int i = 0; i < 9; i++) begin
            instr(OpCall, 2'd0, 10'h200, 10'h040 + i, 1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 10'h200);
            if (i == 7) begin
                check("full_after_8", STACK_FULL, 1'b1);
                check("no_err_at_8", STACK_ERR, 1'b0);
            end
        end
        check("ovf_err", STACK_ERR, 1'b1);
        check("ovf_top_kept", STACK_DOUT, 10'h048);
        for (int k = 0; k < 8; k++) begin
            instr(OpRet, 2'd0, 10'd0, -1, 1'b1, 1'b0, 2'd1, 10'(10'h048 - k), 1'b0,
                  10'(10'h048 - k));
        end
        instr(OpRet, 2'd0, 10'd0, -1, 1'b1, 1'b0, 2'd1, 10'd0, 1'b0, 10'd0);
        check("unf_err", STACK_ERR, 1'b1);
        check("unf_empty", STACK_EMPTY, 1'b1);

        // Wraparound push, then reset mid-EXEC
        instr(OpCall, 2'd0, 10'h050, 10'h3FF, 1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 10'h050);
        check("wrap_top", STACK_DOUT, 10'h000);
        check("wrap_not_empty", STACK_EMPTY, 1'b0);
        instr(OpIntctl, 2'd1, 10'd0, -1, 1'b0, 1'b1, 2'd0, 10'd0, 1'b0, 10'h051);
        OP_CLASS = OpCall; imm = 10'h123;
        @(posedge CLK); #1;
        check("pre_rst_exec", STATE, 2'd1);
        RST = 1'b1;
        #1;
        check("rst_gates_ld", PC_LD, 1'b0);
        check("rst_gates_sel", PC_MUX_SEL, 2'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        check("mid_rst_state", STATE, 2'd0);
        check("mid_rst_empty", STACK_EMPTY, 1'b1);
        check("mid_rst_int_en", INT_EN, 1'b0);
        check("mid_rst_err", STACK_ERR, 1'b0);
        check("mid_rst_pc", pc, 10'h051);
        check("final_drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
